// File: rtl/dbus_wb_master.sv
// dbus_wb_master: MEM-stage data port to a single-beat Wishbone classic master.
// Define DBUS_TIMEOUT_EN to add the BUSY timeout abort and the bus_err_o port.
module dbus_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
`ifdef DBUS_TIMEOUT_EN
    output logic        bus_err_o,
`endif

    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("dbus_wb_master: TIMEOUT_CYCLES must be 2..65535");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        WAIT_STALL
    } state_e;

    state_e      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rd_buf_q, rd_buf_d;

    logic        bus_load;
    logic        bus_clr;
    logic        abort_to;

`ifdef DBUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The cycle that would bring the count to TIMEOUT_CYCLES is the abort cycle.
    assign abort_to = (state_q == BUSY) && !wb_ack_i && !flush_i
                   && (cnt_q == CNT_LAST);
    assign bus_err_o = abort_to;

    always_comb begin
        cnt_d = cnt_q;
        if (bus_load) begin
            cnt_d = '0;
        end else if (state_q == BUSY && !wb_ack_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign abort_to = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        bus_load   = 1'b0;
        bus_clr    = 1'b0;
        rd_buf_d   = rd_buf_q;
        stallreq_o = 1'b0;
        cpu_data_o = '0;

        unique case (state_q)
            IDLE: begin
                stallreq_o = cpu_ce_i && !flush_i;
                if (cpu_ce_i && !flush_i) begin
                    bus_load = 1'b1;
                    state_d  = BUSY;
                end else begin
                    bus_clr = 1'b1;
                end
            end
            BUSY: begin
                stallreq_o = !wb_ack_i && !flush_i && !abort_to;
                if (wb_ack_i && !we_q) begin
                    cpu_data_o = wb_dat_i;
                end
                if (flush_i) begin
                    bus_clr = 1'b1;
                    state_d = IDLE;
                end else if (wb_ack_i) begin
                    bus_clr  = 1'b1;
                    rd_buf_d = we_q ? 32'h0 : wb_dat_i;
                    state_d  = stall_i ? WAIT_STALL : IDLE;
                end else if (abort_to) begin
                    bus_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_STALL: begin
                cpu_data_o = rd_buf_q;
                if (!stall_i || flush_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cyc_d = cyc_q;
        we_d  = we_q;
        sel_d = sel_q;
        adr_d = adr_q;
        dat_d = dat_q;
        if (bus_load) begin
            cyc_d = 1'b1;
            we_d  = cpu_we_i;
            sel_d = cpu_sel_i;
            adr_d = cpu_addr_i;
            dat_d = cpu_data_i;
        end else if (bus_clr) begin
            cyc_d = 1'b0;
            we_d  = 1'b0;
            sel_d = '0;
            adr_d = '0;
            dat_d = '0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q  <= IDLE;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            rd_buf_q <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            rd_buf_q <= rd_buf_d;
        end
    end

    // Single-beat classic cycles: STB always mirrors CYC.
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = we_q;
    assign wb_sel_o = sel_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;

endmodule
